fwd_scoreboard: RTL and testbench

- Parametrised successor to the fixed three-stage RAW handling in the pipelined RV32 core.
- Tracks destination registers of up to DEPTH in-flight instructions in its own shift-register scoreboard.
- Selects the youngest ready forwarding source for rs1/rs2 at decode, and raises a load-use stall when the producing value is not yet available.
- Sits between decoder/register_file and the ID/EX pipeline register; keeps a saturating stall-cycle counter for performance tracing.

---
 rtl/fwd_scoreboard_if.sv | 41 ++++
 rtl/fwd_scoreboard.sv | 87 ++++++++
 tb/tb_fwd_scoreboard.sv | 253 +++++++++++++++++++++++++
 3 files changed

// File: rtl/fwd_scoreboard_if.sv
// Decode-side bundle for fwd_scoreboard: source/dest selects, register-file data,
// per-stage result values, and the resolved operands, stall and stall counter.
interface fwd_scoreboard_if #(
  parameter int unsigned XLEN     = 32,
  parameter int unsigned REG_BITS = 5,
  parameter int unsigned DEPTH    = 3,
  parameter int unsigned CNT_W    = 16
);
  logic                  id_valid;
  logic [REG_BITS-1:0]   id_rs1_sel;
  logic [REG_BITS-1:0]   id_rs2_sel;
  logic                  id_rs1_used;
  logic                  id_rs2_used;
  logic [REG_BITS-1:0]   id_rd_sel;
  logic                  id_wr_en;
  logic                  id_is_load;
  logic                  flush;
  logic [XLEN-1:0]       rgf_rs1_val;
  logic [XLEN-1:0]       rgf_rs2_val;
  logic [DEPTH*XLEN-1:0] stage_val;
  logic [XLEN-1:0]       fwd_rs1_val;
  logic [XLEN-1:0]       fwd_rs2_val;
  logic [3:0]            fwd_rs1_src;
  logic [3:0]            fwd_rs2_src;
  logic                  stall;
  logic [CNT_W-1:0]      stall_cnt;

  modport master (
    output id_valid, id_rs1_sel, id_rs2_sel, id_rs1_used, id_rs2_used,
           id_rd_sel, id_wr_en, id_is_load, flush,
           rgf_rs1_val, rgf_rs2_val, stage_val,
    input  fwd_rs1_val, fwd_rs2_val, fwd_rs1_src, fwd_rs2_src, stall, stall_cnt
  );

  modport slave (
    input  id_valid, id_rs1_sel, id_rs2_sel, id_rs1_used, id_rs2_used,
           id_rd_sel, id_wr_en, id_is_load, flush,
           rgf_rs1_val, rgf_rs2_val, stage_val,
    output fwd_rs1_val, fwd_rs2_val, fwd_rs1_src, fwd_rs2_src, stall, stall_cnt
  );
endinterface

// File: rtl/fwd_scoreboard.sv
// RAW forwarding scoreboard: shift-register of in-flight destinations, youngest-match
// operand forwarding, load-use stall and a saturating stall-cycle counter.
module fwd_scoreboard #(
  parameter int unsigned XLEN       = 32,
  parameter int unsigned REG_BITS   = 5,
  parameter int unsigned DEPTH      = 3,
  parameter int unsigned LOAD_READY = 1,
  parameter int unsigned CNT_W      = 16
) (
  input logic             clk,
  input logic             rst,
  fwd_scoreboard_if.slave bus
);

  typedef struct packed {
    logic                valid;
    logic [REG_BITS-1:0] rd;
    logic                wr;
    logic                load;
  } entry_t;

  typedef struct packed {
    logic            hit;
    logic            rdy;
    logic [3:0]      src;
    logic [XLEN-1:0] val;
  } res_t;

  entry_t [DEPTH-1:0] r_sb;
  logic [CNT_W-1:0]   r_stall_cnt;
  res_t               w_r1;
  res_t               w_r2;
  logic               w_stall;

  // Scan oldest to youngest so the youngest match overwrites; readiness never looks at stage_val.
  function automatic res_t resolve(input entry_t [DEPTH-1:0] sb,
                                   input logic [DEPTH*XLEN-1:0] sv,
                                   input logic [REG_BITS-1:0] sel,
                                   input logic used);
    res_t r;
    r = '0;
    for (int unsigned k = DEPTH; k > 0; k--) begin
      if (sb[k-1].valid && sb[k-1].wr && sb[k-1].rd == sel && sel != '0 && used) begin
        r.hit = 1'b1;
        r.rdy = !sb[k-1].load || ((k - 1) >= LOAD_READY);
        r.src = 4'(k);
        r.val = sv[(k-1)*XLEN +: XLEN];
      end
    end
    return r;
  endfunction

  assign w_r1 = resolve(r_sb, bus.stage_val, bus.id_rs1_sel, bus.id_rs1_used);
  assign w_r2 = resolve(r_sb, bus.stage_val, bus.id_rs2_sel, bus.id_rs2_used);

  assign w_stall = bus.id_valid && ((w_r1.hit && !w_r1.rdy) || (w_r2.hit && !w_r2.rdy));

  assign bus.fwd_rs1_val = (w_r1.hit && w_r1.rdy) ? w_r1.val : bus.rgf_rs1_val;
  assign bus.fwd_rs2_val = (w_r2.hit && w_r2.rdy) ? w_r2.val : bus.rgf_rs2_val;
  assign bus.fwd_rs1_src = w_r1.src;
  assign bus.fwd_rs2_src = w_r2.src;
  assign bus.stall       = w_stall;
  assign bus.stall_cnt   = r_stall_cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sb        <= '0;
      r_stall_cnt <= '0;
    end else begin
      for (int unsigned k = 1; k < DEPTH; k++) begin
        r_sb[k] <= r_sb[k-1];
      end
      if (bus.id_valid && !w_stall && !bus.flush) begin
        r_sb[0].valid <= 1'b1;
        r_sb[0].rd    <= bus.id_rd_sel;
        r_sb[0].wr    <= bus.id_wr_en && (bus.id_rd_sel != '0);
        r_sb[0].load  <= bus.id_is_load;
      end else begin
        r_sb[0] <= '0;
      end
      if (w_stall && (r_stall_cnt != '1)) begin
        r_stall_cnt <= r_stall_cnt + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_fwd_scoreboard.sv
// Directed bench for fwd_scoreboard with an in-bench instruction-history model
// checked every negedge, plus hand-computed literal expectations.
module tb_fwd_scoreboard;
  localparam int XLEN  = 32;
  localparam int RB    = 5;
  localparam int DEPTH = 3;
  localparam int LR    = 1;
  localparam int CW    = 2;
  localparam int CMAX  = (1 << CW) - 1;
  localparam logic [31:0] R1 = 32'h1111_0001;
  localparam logic [31:0] R2 = 32'h2222_0002;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_checks = 0;
  int   n_fail   = 0;

  always #5 clk = ~clk;

  fwd_scoreboard_if #(.XLEN(XLEN), .REG_BITS(RB), .DEPTH(DEPTH), .CNT_W(CW)) bus ();

  fwd_scoreboard #(
    .XLEN(XLEN), .REG_BITS(RB), .DEPTH(DEPTH), .LOAD_READY(LR), .CNT_W(CW)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus.slave)
  );

  // Model: history of what entered the pipeline each cycle, index 0 = youngest.
  typedef struct packed {
    bit          v;
    bit [RB-1:0] rd;
    bit          wr;
    bit          ld;
  } rec_t;

  rec_t mq[$];
  int   m_cnt;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic void resolve(input logic [RB-1:0] r, input logic used,
                                  output bit hit, output bit rdy, output int k);
    hit = 0; rdy = 1; k = 0;
    foreach (mq[i]) begin
      if (!hit && mq[i].v && mq[i].wr && mq[i].rd == r && r != 0 && used) begin
        hit = 1;
        k   = i;
        rdy = !mq[i].ld || (i >= LR);
      end
    end
  endfunction

  task automatic model_eval(output logic [31:0] v1, output logic [31:0] v2,
                            output logic [3:0] s1, output logic [3:0] s2, output bit st);
    bit h1, h2, y1, y2;
    int k1, k2;
    resolve(bus.id_rs1_sel, bus.id_rs1_used, h1, y1, k1);
    resolve(bus.id_rs2_sel, bus.id_rs2_used, h2, y2, k2);
    s1 = h1 ? 4'(k1 + 1) : 4'd0;
    s2 = h2 ? 4'(k2 + 1) : 4'd0;
    v1 = (h1 && y1) ? bus.stage_val[k1*XLEN +: XLEN] : bus.rgf_rs1_val;
    v2 = (h2 && y2) ? bus.stage_val[k2*XLEN +: XLEN] : bus.rgf_rs2_val;
    st = bus.id_valid && ((h1 && !y1) || (h2 && !y2));
  endtask

  always @(posedge clk or posedge rst) begin
    logic [31:0] v1, v2;
    logic [3:0]  s1, s2;
    bit          st;
    rec_t        nr;
    if (rst) begin
      mq.delete();
      repeat (DEPTH) mq.push_back('0);
      m_cnt = 0;
    end else begin
      model_eval(v1, v2, s1, s2, st);
      if (st && m_cnt < CMAX) m_cnt++;
      nr = '0;
      if (bus.id_valid && !st && !bus.flush) begin
        nr.v  = 1;
        nr.rd = bus.id_rd_sel;
        nr.wr = bus.id_wr_en;
        nr.ld = bus.id_is_load;
      end
      mq.push_front(nr);
      void'(mq.pop_back());
    end
  end

  always @(negedge clk) begin
    logic [31:0] v1, v2;
    logic [3:0]  s1, s2;
    bit          st;
    if (!rst) begin
      model_eval(v1, v2, s1, s2, st);
      chk("cyc_fwd1", bus.fwd_rs1_val, v1);
      chk("cyc_fwd2", bus.fwd_rs2_val, v2);
      chk("cyc_src1", 32'(bus.fwd_rs1_src), 32'(s1));
      chk("cyc_src2", 32'(bus.fwd_rs2_src), 32'(s2));
      chk("cyc_stall", 32'(bus.stall), 32'(st));
      chk("cyc_cnt", 32'(bus.stall_cnt), 32'(m_cnt));
    end
  end

  task automatic drv(input bit v, input int rs1, input bit u1, input int rs2, input bit u2,
                     input int rd, input bit wr, input bit ld, input bit fl);
    bus.id_valid    = v;
    bus.id_rs1_sel  = RB'(rs1);
    bus.id_rs1_used = u1;
    bus.id_rs2_sel  = RB'(rs2);
    bus.id_rs2_used = u2;
    bus.id_rd_sel   = RB'(rd);
    bus.id_wr_en    = wr;
    bus.id_is_load  = ld;
    bus.flush       = fl;
  endtask

  task automatic set_sv(input logic [31:0] s0, input logic [31:0] s1, input logic [31:0] s2);
    bus.stage_val = {s2, s1, s0};
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  initial begin
    drv(0, 0, 0, 0, 0, 0, 0, 0, 0);
    bus.rgf_rs1_val = R1;
    bus.rgf_rs2_val = R2;
    set_sv('0, '0, '0);
    #3;
    chk("rst_stall", 32'(bus.stall), 0);
    chk("rst_cnt", 32'(bus.stall_cnt), 0);
    chk("rst_src1", 32'(bus.fwd_rs1_src), 0);
    chk("rst_fwd1", bus.fwd_rs1_val, R1);
    #9 rst = 1'b0;
    tick;

    // addi x5 then add x6,x5,x5
    drv(1, 0, 0, 0, 0, 5, 1, 0, 0); tick;
    set_sv(32'h11, 32'h0, 32'h0);
    drv(1, 5, 1, 5, 1, 6, 1, 0, 0); #1;
    chk("s0_fwd1", bus.fwd_rs1_val, 32'h11);
    chk("s0_fwd2", bus.fwd_rs2_val, 32'h11);
    chk("s0_src1", 32'(bus.fwd_rs1_src), 1);
    chk("s0_src2", 32'(bus.fwd_rs2_src), 1);
    chk("s0_stall", 32'(bus.stall), 0);
    tick;

    // lw x7 then add x8,x7,x0
    drv(1, 0, 0, 0, 0, 7, 1, 1, 0); tick;
    drv(1, 7, 1, 0, 1, 8, 1, 0, 0); #1;
    chk("lu_stall", 32'(bus.stall), 1);
    chk("lu_src1", 32'(bus.fwd_rs1_src), 1);
    tick;
    set_sv(32'h0, 32'hDEAD_BEEF, 32'h0); #1;
    chk("lu_stall_after", 32'(bus.stall), 0);
    chk("lu_cnt", 32'(bus.stall_cnt), 1);
    chk("lu_src1_b", 32'(bus.fwd_rs1_src), 2);
    chk("lu_fwd1", bus.fwd_rs1_val, 32'hDEAD_BEEF);
    chk("lu_src2", 32'(bus.fwd_rs2_src), 0);
    chk("lu_fwd2", bus.fwd_rs2_val, R2);
    tick;

    // write to x0, then x10 writer read through an unused rs2
    drv(1, 0, 0, 0, 0, 0, 1, 0, 0); tick;
    drv(1, 0, 0, 0, 0, 10, 1, 0, 0); tick;
    drv(1, 0, 1, 10, 0, 15, 1, 0, 0); #1;
    chk("x0_src1", 32'(bus.fwd_rs1_src), 0);
    chk("x0_fwd1", bus.fwd_rs1_val, R1);
    chk("unused_src2", 32'(bus.fwd_rs2_src), 0);
    chk("unused_fwd2", bus.fwd_rs2_val, R2);
    chk("x0_stall", 32'(bus.stall), 0);
    tick;

    // x9 at stages 0 and 2: youngest wins
    drv(1, 0, 0, 0, 0, 9, 1, 0, 0); tick;
    drv(1, 0, 0, 0, 0, 11, 1, 0, 0); tick;
    drv(1, 0, 0, 0, 0, 9, 1, 0, 0); tick;
    set_sv(32'hAAAA, 32'h5555, 32'hBBBB);
    drv(1, 9, 1, 9, 1, 16, 1, 0, 0); #1;
    chk("dm_fwd1", bus.fwd_rs1_val, 32'hAAAA);
    chk("dm_fwd2", bus.fwd_rs2_val, 32'hAAAA);
    chk("dm_src1", 32'(bus.fwd_rs1_src), 1);
    tick;

    // youngest match is an unready load; older ready ALU result is ignored
    drv(1, 0, 0, 0, 0, 12, 1, 0, 0); tick;
    drv(1, 0, 0, 0, 0, 12, 1, 1, 0); tick;
    drv(1, 12, 1, 0, 0, 17, 1, 0, 0); #1;
    chk("yl_stall", 32'(bus.stall), 1);
    chk("yl_src1", 32'(bus.fwd_rs1_src), 1);
    tick;
    chk("yl_src1_b", 32'(bus.fwd_rs1_src), 2);
    chk("yl_fwd1", bus.fwd_rs1_val, 32'h5555);
    chk("yl_cnt", 32'(bus.stall_cnt), 2);
    tick;

    // flushed writer of x3 leaves no trace
    drv(1, 0, 0, 0, 0, 3, 1, 0, 1); tick;
    drv(1, 3, 1, 3, 1, 18, 1, 0, 0); #1;
    chk("fl_src1", 32'(bus.fwd_rs1_src), 0);
    chk("fl_src2", 32'(bus.fwd_rs2_src), 0);
    chk("fl_stall", 32'(bus.stall), 0);
    tick;

    // flush together with a load-use stall
    drv(1, 0, 0, 0, 0, 13, 1, 1, 0); tick;
    drv(1, 13, 1, 0, 0, 19, 1, 0, 1); #1;
    chk("fs_stall", 32'(bus.stall), 1);
    tick;
    chk("fs_cnt", 32'(bus.stall_cnt), 3);
    drv(1, 13, 1, 0, 0, 19, 1, 0, 0); #1;
    chk("fs_src1", 32'(bus.fwd_rs1_src), 2);
    tick;

    // asynchronous reset in the middle of a stall
    drv(1, 0, 0, 0, 0, 14, 1, 1, 0); tick;
    drv(1, 14, 1, 0, 0, 20, 1, 0, 0); #1;
    chk("rs_stall_pre", 32'(bus.stall), 1);
    rst = 1'b1; #1;
    chk("rs_stall", 32'(bus.stall), 0);
    chk("rs_cnt", 32'(bus.stall_cnt), 0);
    chk("rs_src1", 32'(bus.fwd_rs1_src), 0);
    chk("rs_fwd1", bus.fwd_rs1_val, R1);
    #4 rst = 1'b0;
    tick;

    // six stall cycles saturate a 2-bit counter at 3
    for (int i = 0; i < 6; i++) begin
      drv(1, 0, 0, 0, 0, 21, 1, 1, 0); tick;
      drv(1, 21, 1, 0, 0, 22, 1, 0, 0); #1;
      chk("sat_stall", 32'(bus.stall), 1);
      tick;
      chk("sat_cnt", 32'(bus.stall_cnt), (i + 1 > 3) ? 3 : i + 1);
    end
    drv(0, 0, 0, 0, 0, 0, 0, 0, 0);
    repeat (2) tick;
    chk("sat_final", 32'(bus.stall_cnt), 3);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
